// File: rtl/dpp_table.sv
// dpp_table: round-robin drainer of philosopher HUNGRY(0)/DONE(1) events that tracks forks and pulses may_eat grants (ports: clk, reset, philo_empty/philo_data in, philo_ack/may_eat/eating/fork_busy/protocol_err out)
module dpp_table #(
  parameter  int N_PHILO = 5,
  localparam int PTR_W   = $clog2(N_PHILO)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PHILO-1:0] philo_empty,
  input  logic [N_PHILO-1:0] philo_data,
  output logic [N_PHILO-1:0] philo_ack,
  output logic [N_PHILO-1:0] may_eat,
  output logic [N_PHILO-1:0] eating,
  output logic [N_PHILO-1:0] fork_busy,
  output logic               protocol_err
);
  localparam logic HUNGRY = 1'b0;
  typedef enum logic [1:0] {SCAN, HANDLE, CHK_L, CHK_R} st_t;
  st_t st_q;
  logic [PTR_W-1:0] ptr_q, idx_q, gj;
  logic ev_q, err_q, do_grant;
  logic [N_PHILO-1:0] hungry_q, eating_q, fork_q, ack_q, may_q;
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (int'(p) == N_PHILO - 1) ? '0 : p + 1'b1;
  endfunction
  function automatic logic [PTR_W-1:0] prv(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(N_PHILO - 1) : p - 1'b1;
  endfunction
  always_comb begin
    gj = (st_q == CHK_L) ? prv(idx_q) : (st_q == CHK_R) ? nxt(idx_q) : idx_q;
    do_grant = ((st_q == HANDLE && ev_q == HUNGRY && !eating_q[idx_q] && !hungry_q[idx_q]) ||
                ((st_q == CHK_L || st_q == CHK_R) && hungry_q[gj])) &&
               !fork_q[gj] && !fork_q[nxt(gj)];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= SCAN;
      ptr_q    <= '0;
      idx_q    <= '0;
      ev_q     <= 1'b0;
      err_q    <= 1'b0;
      hungry_q <= '0;
      eating_q <= '0;
      fork_q   <= '0;
      ack_q    <= '0;
      may_q    <= '0;
    end else begin
      ack_q <= '0;
      may_q <= '0;
      case (st_q)
        SCAN: begin
          if (!philo_empty[ptr_q]) begin
            ev_q         <= philo_data[ptr_q];
            idx_q        <= ptr_q;
            ack_q[ptr_q] <= 1'b1;
            st_q         <= HANDLE;
          end else ptr_q <= nxt(ptr_q);
        end
        HANDLE: begin
          ptr_q <= nxt(idx_q);
          st_q  <= SCAN;
          if (ev_q == HUNGRY) begin
            if (eating_q[idx_q] || hungry_q[idx_q]) err_q <= 1'b1;
            else if (!do_grant) hungry_q[idx_q] <= 1'b1;
          end else if (!eating_q[idx_q]) err_q <= 1'b1;
          else begin
            eating_q[idx_q]    <= 1'b0;
            fork_q[idx_q]      <= 1'b0;
            fork_q[nxt(idx_q)] <= 1'b0;
            st_q               <= CHK_L;
          end
        end
        CHK_L:   st_q <= CHK_R;
        default: st_q <= SCAN;
      endcase
      if (do_grant) begin
        may_q[gj]       <= 1'b1;
        eating_q[gj]    <= 1'b1;
        hungry_q[gj]    <= 1'b0;
        fork_q[gj]      <= 1'b1;
        fork_q[nxt(gj)] <= 1'b1;
      end
    end
  end
  assign philo_ack    = ack_q;
  assign may_eat      = may_q;
  assign eating       = eating_q;
  assign fork_busy    = fork_q;
  assign protocol_err = err_q;
endmodule

// File: tb/tb_dpp_table.sv
// tb_dpp_table: directed checks of dpp_table with five and three philosophers
module tb_dpp_table;
  localparam logic H = 1'b0, D = 1'b1;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [4:0] e5 = '1, d5 = '0, ack5, may5, eat5, fb5;
  logic [2:0] e3 = '1, d3 = '0, ack3, may3, eat3, fb3;
  logic err5, err3;
  int nvec = 0, nerr = 0;
  dpp_table #(.N_PHILO(5)) u5 (.clk(clk), .reset(reset), .philo_empty(e5), .philo_data(d5),
    .philo_ack(ack5), .may_eat(may5), .eating(eat5), .fork_busy(fb5), .protocol_err(err5));
  dpp_table #(.N_PHILO(3)) u3 (.clk(clk), .reset(reset), .philo_empty(e3), .philo_data(d3),
    .philo_ack(ack3), .may_eat(may3), .eating(eat3), .fork_busy(fb3), .protocol_err(err3));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input bit s3, input int i, input logic ev);
    bit seen = 1'b0;
    if (s3) begin e3[i] = 1'b0; d3[i] = ev; end
    else begin e5[i] = 1'b0; d5[i] = ev; end
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      seen = s3 ? ack3[i] : ack5[i];
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("ack_onehot", s3 ? 32'(ack3) : 32'(ack5), 32'd1 << i);
    if (s3) e3[i] = 1'b1;
    else e5[i] = 1'b1;
  endtask
  initial begin
    int order, cnt, adj;
    logic [4:0] mo;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_outs5", {ack5, may5, eat5, fb5, err5}, 0);
    chk("reset_outs3", {ack3, may3, eat3, fb3, err3}, 0);
    send(0, 2, H);
    tick();
    chk("g2_may", may5, 5'b00100);
    chk("g2_eat", eat5, 5'b00100);
    chk("g2_fork", fb5, 5'b01100);
    chk("g2_ack_drop", ack5, 0);
    tick();
    chk("g2_pulse_len", may5, 0);
    send(0, 3, H);
    tick();
    chk("h3_no_grant", may5, 0);
    chk("h3_eat", eat5, 5'b00100);
    send(0, 2, D);
    tick();
    chk("d2_release_eat", eat5, 0);
    chk("d2_release_fork", fb5, 0);
    tick();
    chk("d2_chkl", may5, 0);
    tick();
    chk("d2_chkr_may", may5, 5'b01000);
    chk("d2_chkr_eat", eat5, 5'b01000);
    chk("d2_chkr_fork", fb5, 5'b11000);
    send(0, 3, D);
    tick(); tick(); tick();
    chk("d3_idle_eat", eat5, 0);
    chk("d3_idle_fork", fb5, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e5 = '0; d5 = '0;
    order = 0; cnt = 0; adj = 0; mo = '0;
    for (int k = 0; k < 60 && cnt < 5; k++) begin
      tick();
      mo |= may5;
      if ((eat5 & {eat5[3:0], eat5[4]}) != 0) adj++;
      for (int i = 0; i < 5; i++) if (ack5[i]) begin order = order * 10 + i; e5[i] = 1'b1; cnt++; end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      mo |= may5;
      if ((eat5 & {eat5[3:0], eat5[4]}) != 0) adj++;
    end
    chk("all_order", order, 1234);
    chk("all_grants", mo, 5'b00101);
    chk("all_eat", eat5, 5'b00101);
    chk("all_fork", fb5, 5'b01111);
    chk("all_adjacent", adj, 0);
    chk("all_no_err", err5, 0);
    send(0, 3, H);
    tick();
    chk("rehungry_err", err5, 1);
    chk("rehungry_fork", fb5, 5'b01111);
    chk("rehungry_eat", eat5, 5'b00101);
    send(0, 1, D);
    tick();
    chk("baddone_err", err5, 1);
    chk("baddone_fork", fb5, 5'b01111);
    tick(); tick();
    chk("err_sticky", err5, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_clears_err", err5, 0);
    send(0, 2, H);
    reset = 1'b1;
    tick();
    chk("midreset_outs", {ack5, may5, eat5, fb5, err5}, 0);
    reset = 1'b0;
    mo = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      mo |= may5;
    end
    chk("midreset_no_grant", mo, 0);
    chk("midreset_eat", eat5, 0);
    send(1, 1, H);
    tick();
    chk("n3_g1_may", may3, 3'b010);
    send(1, 0, H);
    tick();
    send(1, 2, H);
    tick();
    chk("n3_eat", eat3, 3'b010);
    chk("n3_fork", fb3, 3'b110);
    send(1, 1, D);
    tick();
    chk("n3_release_fork", fb3, 0);
    tick();
    chk("n3_chkl_may", may3, 3'b001);
    tick();
    chk("n3_chkr_may", may3, 0);
    chk("n3_chkr_eat", eat3, 3'b001);
    chk("n3_chkr_fork", fb3, 3'b011);
    chk("n3_no_err", err3, 0);
    send(1, 0, D);
    tick(); tick();
    chk("n3_p2_waiting_grant", may3, 3'b100);
    chk("n3_p2_eat", eat3, 3'b100);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dpp_table.md
Name: dpp_table

Overview:
- Table arbiter for the dining-philosophers design; it is the consumer and responder end of each philosopher's event FIFO.
- Drains HUNGRY/DONE events from N philosopher output FIFOs in round-robin order.
- Tracks ownership of the N forks.
- Grants eating rights by pulsing the per-philosopher may_eat line, which feeds that philosopher's input FIFO.

Parameters:
- N_PHILO, 5, number of philosophers and forks; legal range 3..16.
- PTR_W, log2(N_PHILO), width of the scan pointer and the philosopher index; derived, do not override.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high.
- philo_empty  input  N_PHILO  per-philosopher event FIFO empty flag.
- philo_data  input  N_PHILO  per-philosopher FIFO head. Valid while the matching empty bit is 0 (first-word-fall-through). Encoded with the `PHILO_HUNGRY / `PHILO_DONE defines from dpp.v.
- philo_ack  output  N_PHILO  one-cycle pop strobe per FIFO.
- may_eat  output  N_PHILO  one-cycle grant pulse per philosopher.
- eating  output  N_PHILO  bit i set while philosopher i holds both forks.
- fork_busy  output  N_PHILO  bit f set while fork f is owned.
- protocol_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Fork map: philosopher i uses fork i (left) and fork (i+1) mod N (right). Left neighbour is (i-1) mod N; right neighbour is (i+1) mod N.
- Internal state: hungry_q[N], eating[N], fork_busy[N], ptr, idx, ev, and an FSM with states SCAN, HANDLE, CHK_L, CHK_R.
- Reset, synchronous: all outputs 0; hungry_q = 0; ptr = 0; FSM = SCAN. Reset asserted mid-operation aborts any pending check and drops any pending ack or grant on the next edge.
- SCAN:
  - If philo_empty[ptr] == 0: ev <= philo_data[ptr]; idx <= ptr; philo_ack[ptr] <= 1 for exactly one cycle; go to HANDLE.
  - Else: ptr <= ptr+1, wrapping N-1 -> 0.
  - At most one ack bit is high in any cycle.
- HANDLE. In every case ptr <= idx+1 (wrap).
  - HUNGRY with eating[idx] or hungry_q[idx] already set: protocol_err <= 1, event dropped, go to SCAN.
  - HUNGRY, otherwise, with both forks free: grant idx, go to SCAN.
  - HUNGRY, otherwise, with a fork busy: hungry_q[idx] <= 1, go to SCAN.
  - DONE with eating[idx] == 0: protocol_err <= 1, go to SCAN.
  - DONE, otherwise: clear eating[idx] and free both of its forks; go to CHK_L.
- CHK_L: if the left neighbour has hungry_q set and both its forks are free, using post-release fork state, grant it. Go to CHK_R.
- CHK_R: same check for the right neighbour, using fork state as updated by CHK_L. Go to SCAN. The left neighbour always has priority over the right (matters for N=3, where the two neighbours share a fork).
- Grant of philosopher j, as one registered edge:
  - may_eat[j] <= 1 for one cycle;
  - eating[j] <= 1;
  - hungry_q[j] <= 0;
  - both forks of j busy.
  - Grant pulses never exceed one cycle and never repeat for a single request.
- Latency from SCAN detecting non-empty:
  - ack is high the next cycle;
  - a HUNGRY grant is visible 2 cycles after detection;
  - a neighbour grant after DONE is visible 3 cycles (left) or 4 cycles (right) after detection.
- FIFO pop timing: ptr always moves off idx, and N >= 3, so a popped FIFO is not re-sampled for at least 2 cycles. This covers the FIFO empty-flag update latency.
- Invariants:
  - adjacent philosophers are never both eating;
  - fork_busy equals the OR of the forks owned by eating philosophers;
  - popcount(eating) <= floor(N/2).

Test Plan:
- Reset, then philosopher 2 FIFO = {HUNGRY} -> philo_ack[2] pulses once; may_eat[2] pulses 2 cycles after detection; eating = 5'b00100; fork_busy = 5'b01100.
- Philosopher 2 eating, then philosopher 3 HUNGRY -> no grant; hungry_q[3] = 1. Then philosopher 2 DONE -> forks 2 and 3 freed; may_eat[3] pulses in CHK_R; fork_busy = 5'b11000.
- All five FIFOs hold HUNGRY at once -> serviced in ptr order 0..4; grants go to 0 and 2 only; eating = 5'b00101; no two adjacent bits ever set.
- N_PHILO=3: philosophers 0 and 2 hungry while 1 eats, then 1 sends DONE -> only the left neighbour (0) is granted; 2 stays hungry.
- DONE from a non-eating philosopher, or a second HUNGRY from a hungry philosopher -> protocol_err = 1 and stays 1; fork state unchanged.
- Reset asserted the cycle after an ack, while in HANDLE -> next cycle all outputs 0 and FSM in SCAN; no may_eat pulse is emitted.
